// File: rtl/line_data_memory.sv
// Line-wide backing store behind the data cache: accepts one line read or write,
// then answers with a single-cycle ack after a fixed access latency.
module line_data_memory #(
  parameter int LINE_BITS  = 256,
  parameter int DEPTH_LOG2 = 9,
  parameter int LATENCY    = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          addr_i,
  input  logic [LINE_BITS-1:0] data_i,
  input  logic                 enable_i,
  input  logic                 write_i,
  output logic                 ack_o,
  output logic [LINE_BITS-1:0] data_o
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t                state;
  logic [7:0]            count;
  logic [DEPTH_LOG2-1:0] idx;
  logic [LINE_BITS-1:0]  wdata;
  logic                  wr;
  logic [LINE_BITS-1:0]  mem [2**DEPTH_LOG2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};

  // BUSY is held until the counter has drained to zero, so ACK is entered
  // exactly LATENCY edges after the accept edge (LATENCY=1 spends one edge in BUSY).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      count  <= '0;
      idx    <= '0;
      wdata  <= '0;
      wr     <= 1'b0;
      ack_o  <= 1'b0;
      data_o <= '0;
    end else begin
      ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_i) begin
            idx   <= addr_i[DEPTH_LOG2+4:5];
            wdata <= data_i;
            wr    <= write_i;
            count <= LAT_M1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (count == 8'd0) begin
            state <= ACK;
            ack_o <= 1'b1;
            if (!wr) data_o <= mem[idx];
          end else begin
            count <= count - 8'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The array is not reset; a reset during ACK moves state to IDLE before the commit edge.
  always_ff @(posedge clk_i) begin
    if (state == ACK && wr) mem[idx] <= wdata;
  end

endmodule
